alu_seq: RTL and testbench

Parametrised sequential ALU, successor to the 16-bit single-shot ALU. It runs add, subtract and logic operations in one cycle. Signed multiply (shift-add) and signed divide (restoring) are iterative, one bit per clock, behind a start/busy/done handshake. It sits in the datapath between the register-file read ports and the writeback mux; the controller must hold off issue while `busy` is high.

---
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU.
// Single-cycle ADD/SUB/AND/OR/XOR; iterative signed MUL (shift-add on
// magnitudes) and, when ALU_DIV_EN is defined, iterative signed DIV
// (restoring, on magnitudes). Sign fix-up and result registration
// happen in FIN. Without ALU_DIV_EN, code 0101 behaves as a NOP.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       functCode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             o,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;
  localparam logic [3:0] F_XOR = 4'b0110;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state_q, state_d;

  logic [3:0]         code_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcd;
  logic [WIDTH-1:0]   mlr;

  logic [WIDTH-1:0]   res_d, rem_d;
  logic               o_d;
  logic [WIDTH-1:0]   sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic               iter_req;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] dq, dr, db;
  logic [WIDTH:0]   dsh, dtrial;
  logic             dge;

  assign iter_req = (functCode == F_MUL) || (functCode == F_DIV);
  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign dsh    = {dr, dq[WIDTH-1]};
  assign dtrial = dsh - {1'b0, db};
  assign dge    = ~dtrial[WIDTH];
`else
  assign iter_req = (functCode == F_MUL);
`endif

  assign busy = (state_q != IDLE);
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // State register.
  // NOTE: every sequential block uses non-blocking assignment so all
  // registers update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a start is only looked at while idle.
  // NOTE: defaults are assigned first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = iter_req ? CALC : FIN;
      CALC:    if (cnt == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final result selection from latched operands and iteration state.
  always_comb begin
    res_d = '0;
    rem_d = '0;
    o_d   = 1'b0;
    prod  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc : acc;
    case (code_q)
      F_ADD: begin
        res_d = sum;
        o_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      F_SUB: begin
        res_d = diff;
        o_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      F_AND: res_d = a_q & b_q;
      F_OR:  res_d = a_q | b_q;
      F_XOR: res_d = a_q ^ b_q;
      F_MUL: begin
        {rem_d, res_d} = prod;
        o_d = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
      end
`ifdef ALU_DIV_EN
      F_DIV: begin
        if (b_q == '0) begin
          res_d = '1;
          rem_d = a_q;
          o_d   = 1'b1;
        end else if (a_q == MIN_V && b_q == '1) begin
          res_d = MIN_V;
          rem_d = '0;
          o_d   = 1'b1;
        end else begin
          res_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -dq : dq;
          rem_d = a_q[WIDTH-1] ? -dr : dr;
        end
      end
`endif
      default: ;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcd       <= '0;
      mlr       <= '0;
`ifdef ALU_DIV_EN
      dq        <= '0;
      dr        <= '0;
      db        <= '0;
`endif
      result    <= '0;
      remainder <= '0;
      o         <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_q == FIN);
      case (state_q)
        IDLE: if (start) begin
          code_q <= functCode;
          a_q    <= op1;
          b_q    <= op2;
          cnt    <= '0;
          acc    <= '0;
          mcd    <= {{WIDTH{1'b0}}, mag(op1)};
          mlr    <= mag(op2);
`ifdef ALU_DIV_EN
          dq     <= mag(op1);
          dr     <= '0;
          db     <= mag(op2);
`endif
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= acc + (mlr[0] ? mcd : '0);
          mcd <= mcd << 1;
          mlr <= mlr >> 1;
`ifdef ALU_DIV_EN
          dr  <= dge ? dtrial[WIDTH-1:0] : dsh[WIDTH-1:0];
          dq  <= {dq[WIDTH-2:0], dge};
`endif
        end
        FIN: begin
          result    <= res_d;
          remainder <= rem_d;
          o         <= o_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16 and WIDTH=8 instances).
// Expectations for code 0101 follow whether ALU_DIV_EN is defined.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  functCode;
  logic [15:0] op1, op2, result, remainder;
  logic        o, busy, done;

  logic        start8;
  logic [3:0]  fc8;
  logic [7:0]  a8, b8, res8, rem8;
  logic        o8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .functCode(functCode),
    .op1(op1), .op2(op2), .result(result), .remainder(remainder),
    .o(o), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .functCode(fc8),
    .op1(a8), .op2(b8), .result(res8), .remainder(rem8),
    .o(o8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and count cycles from the accepting edge to done.
  task automatic run(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                     output int lat);
    @(negedge clk);
    functCode = code; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_op(input string tag, input logic [3:0] code,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic [15:0] erem,
                           input logic eo, input int elat);
    int lat;
    run(code, a, b, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, result, er);
    check({tag, "_rem"}, remainder, erem);
    check({tag, "_o"}, o, eo);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, done_cyc, lat;
    logic [15:0] cap_res, cap_rem;

    rst = 1'b1; start = 1'b0; functCode = '0; op1 = '0; op2 = '0;
    start8 = 1'b0; fc8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 16'h0);
    check("rst_rem", remainder, 16'h0);
    check("rst_o", o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    // Single-cycle operations.
    expect_op("add1", 4'b0000, 16'h1111, 16'h8888, 16'h9999, 16'h0, 1'b0, 1);
    expect_op("add_ovf", 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1'b1, 1);
    expect_op("sub_ovf", 4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 1'b1, 1);
    expect_op("sub", 4'b0001, 16'h0005, 16'h0007, 16'hFFFE, 16'h0, 1'b0, 1);
    expect_op("and", 4'b0010, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 1'b0, 1);
    expect_op("or", 4'b0011, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0, 1'b0, 1);
    expect_op("xor", 4'b0110, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0, 1'b0, 1);
    expect_op("nop", 4'b1111, 16'h1234, 16'h5678, 16'h0, 16'h0, 1'b0, 1);

    // Multiply.
    expect_op("mul1", 4'b0100, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b0, 17);
    expect_op("mul_ovf", 4'b0100, 16'h4000, 16'h0002, 16'h8000, 16'h0000, 1'b1, 17);
    expect_op("mul_neg", 4'b0100, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 17);
    expect_op("mul_min", 4'b0100, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b1, 17);

    // Divide, or NOP when the divider is not built.
`ifdef ALU_DIV_EN
    expect_op("div_neg", 4'b0101, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    expect_op("div_zero", 4'b0101, 16'h0007, 16'h0000, 16'hFFFF, 16'h0007, 1'b1, 17);
    expect_op("div_minm1", 4'b0101, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 17);
    expect_op("div_pos", 4'b0101, 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 17);
`else
    expect_op("div_nop", 4'b0101, 16'd20, 16'd3, 16'h0, 16'h0, 1'b0, 1);
`endif

    // MUL 3*4 with an ignored start and operand changes while busy.
    @(negedge clk);
    functCode = 4'b0100; op1 = 16'd3; op2 = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; done_cyc = 0; cap_res = '0; cap_rem = '1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1; functCode = 4'b0000; op1 = 16'd100;
      end else begin
        start = 1'b0;
      end
      if (c == 8) op1 = 16'h0055;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_cyc = c;
        cap_res = result;
        cap_rem = remainder;
      end
    end
    check("busy_ign_ndone", ndone, 1);
    check("busy_ign_lat", done_cyc, 17);
    check("busy_ign_res", cap_res, 16'd12);
    check("busy_ign_rem", cap_rem, 16'd0);

    // Reset in the middle of an iterative operation.
    @(negedge clk);
`ifdef ALU_DIV_EN
    functCode = 4'b0101;
`else
    functCode = 4'b0100;
`endif
    op1 = 16'd1000; op2 = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_result", result, 16'h0);
    check("mid_rst_rem", remainder, 16'h0);
    check("mid_rst_o", o, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    expect_op("post_rst_add", 4'b0000, 16'd2, 16'd3, 16'd5, 16'h0, 1'b0, 1);

    // WIDTH=8 multiply.
    @(negedge clk);
    fc8 = 4'b0100; a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_mul_lat", lat, 9);
    check("w8_mul_prod", {rem8, res8}, 16'h3F01);
    check("w8_mul_o", o8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
